// File: rtl/spi_packet_processor.sv
// Length-prefixed SPI packet processor: buffers a payload, then replies with
// echo, reversed echo, or echo plus XOR checksum; oversized packets get an error word.
module spi_packet_processor #(
  parameter int                DATA_W   = 8,
  parameter int                MAX_LEN  = 64,
  parameter logic [DATA_W-1:0] ERR_CODE = '1
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic [DATA_W-1:0] byte_recv,
  input  logic              valid,
  input  logic              busy,
  input  logic [1:0]        mode,
  output logic              write,
  output logic [DATA_W-1:0] byte_send,
  output logic              pkt_err,
  output logic              idle
);

  localparam int                IDX_W = $clog2(MAX_LEN + 1);
  localparam int                AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int                DEPTH = 2 ** AW;
  localparam logic [DATA_W-1:0] MAX_N = DATA_W'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    DROP,
    HDR,
    SEND,
    CSUM,
    ERR
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] len;
  logic              rev;
  logic              csum;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] chk;

  logic [DATA_W-1:0] buffer [DEPTH];

  logic              can_tx;
  logic              last;
  logic [AW-1:0]     addr;

  // A write may only be launched from a quiet cycle, so pulses never merge.
  assign can_tx = !busy && !write;
  // cnt is DATA_W wide because a dropped packet may be longer than the buffer.
  assign last   = (cnt == len - 1'b1);
  assign addr   = idx[AW-1:0];
  assign idle   = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst_L && state == RECV && valid) begin
      buffer[addr] <= byte_recv;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state     <= IDLE;
      write     <= 1'b0;
      byte_send <= '0;
      pkt_err   <= 1'b0;
      len       <= '0;
      rev       <= 1'b0;
      csum      <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      chk       <= '0;
    end else begin
      write   <= 1'b0;
      pkt_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid) begin
            len  <= byte_recv;
            rev  <= (mode == 2'b01);
            csum <= (mode == 2'b10);
            idx  <= '0;
            cnt  <= '0;
            chk  <= '0;
            if (byte_recv == '0) begin
              state <= IDLE;
            end else if (byte_recv > MAX_N) begin
              pkt_err <= 1'b1;
              state   <= DROP;
            end else begin
              state <= RECV;
            end
          end
        end
        RECV: begin
          if (valid) begin
            chk <= chk ^ byte_recv;
            idx <= idx + 1'b1;
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= HDR;
            end
          end
        end
        DROP: begin
          if (valid) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= ERR;
            end
          end
        end
        HDR: begin
          if (can_tx) begin
            write     <= 1'b1;
            byte_send <= csum ? len + 1'b1 : len;
            cnt       <= '0;
            idx       <= rev ? IDX_W'(len - 1'b1) : '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (can_tx) begin
            write     <= 1'b1;
            byte_send <= buffer[addr];
            cnt       <= cnt + 1'b1;
            if (last) begin
              state <= csum ? CSUM : IDLE;
            end else begin
              // Only step while words remain, so a reverse walk never underflows.
              idx <= rev ? idx - 1'b1 : idx + 1'b1;
            end
          end
        end
        CSUM: begin
          if (can_tx) begin
            write     <= 1'b1;
            byte_send <= chk;
            state     <= IDLE;
          end
        end
        ERR: begin
          if (can_tx) begin
            write     <= 1'b1;
            byte_send <= ERR_CODE;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_packet_processor.sv
// Randomized bench for spi_packet_processor: a packet-level reply model feeds an
// expected-word queue that a per-cycle monitor drains and checks.
`timescale 1ns/1ps
module tb_spi_packet_processor;

  localparam int         DATA_W  = 8;
  localparam int         MAX_LEN = 64;
  localparam logic [7:0] ERR_W   = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_L = 1'b0;
  logic [7:0] byte_recv = 8'h00;
  logic       valid = 1'b0;
  logic       busy = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       write;
  logic [7:0] byte_send;
  logic       pkt_err;
  logic       idle;

  always #5 clk = ~clk;

  spi_packet_processor #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .ERR_CODE(ERR_W)
  ) dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .byte_recv(byte_recv),
    .valid    (valid),
    .busy     (busy),
    .mode     (mode),
    .write    (write),
    .byte_send(byte_send),
    .pkt_err  (pkt_err),
    .idle     (idle)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl[$];
  int         wr_cyc[$];
  int         cyc = 0;
  int         pkt_err_cnt = 0;
  int         pkt_err_exp = 0;
  bit         mon_en = 1'b0;
  bit         busy_rand = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_write = 1'b0;
  logic       prev_rst = 1'b0;
  logic       prev_pkt_err = 1'b0;
  logic [7:0] prev_bs = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // Outputs are sampled on the falling edge; prev_* hold what the DUT saw at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (mon_en && prev_rst) begin
      if (write) begin
        check("write_handshake", {30'd0, prev_busy, prev_write}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual %0h required none", byte_send);
        end else begin
          check("byte_send", {24'd0, byte_send}, {24'd0, exp_q.pop_front()});
        end
        wr_cyc.push_back(cyc);
      end else begin
        check("byte_send_stable", {24'd0, byte_send}, {24'd0, prev_bs});
      end
      if (pkt_err) begin
        pkt_err_cnt++;
        check("pkt_err_one_cycle", {31'd0, prev_pkt_err}, 32'd0);
      end
    end
    prev_busy    = busy;
    prev_write   = write;
    prev_rst     = rst_L;
    prev_pkt_err = pkt_err;
    prev_bs      = byte_send;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy_rand) busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    byte_recv = w;
    valid     = 1'b1;
    tick();
    valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!idle && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, {31'd0, (n < 3000)}, 32'd1);
    tick();
  endtask

  // Reply rules stated directly: nothing for N=0, one error word for N>MAX_LEN,
  // otherwise header, payload (forward or backward), optional XOR word.
  task automatic model(input int n, input logic [1:0] m);
    logic [7:0] x;
    if (n == 0) return;
    if (n > MAX_LEN) begin
      exp_q.push_back(ERR_W);
      pkt_err_exp++;
      return;
    end
    exp_q.push_back((m == 2'b10) ? 8'(n + 1) : 8'(n));
    if (m == 2'b01) begin
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(pl[i]);
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back(pl[i]);
    end
    if (m == 2'b10) begin
      x = 8'h00;
      for (int i = 0; i < n; i++) x = x ^ pl[i];
      exp_q.push_back(x);
    end
  endtask

  task automatic send_pkt(input int n, input logic [1:0] m, input bit rnd, input bit use_model);
    mode = m;
    if (use_model) model(n, m);
    send_word(8'(n), rnd ? int'($urandom_range(0, 2)) : 0);
    for (int i = 0; i < n; i++) begin
      if (rnd) mode = 2'($urandom);
      send_word(pl[i], (rnd && i != n - 1) ? int'($urandom_range(0, 2)) : 0);
    end
    if (rnd && n != 0) send_word(8'($urandom), 0);
    wait_idle("pkt");
    check("exp_drained", exp_q.size(), 32'd0);
    check("pkt_err_count", pkt_err_cnt, pkt_err_exp);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    int n;
    int r;
    logic [1:0] m;

    rst_L = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_byte_send", {24'd0, byte_send}, 32'd0);
    check("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    @(posedge clk);
    #1;
    rst_L  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Echo with back-to-back payload: replies every second cycle.
    pl = '{8'hA1, 8'hB2, 8'hC3};
    exp_q = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
    wc0 = wr_cyc.size();
    send_pkt(3, 2'b00, 1'b0, 1'b0);
    check("echo_write_count", wr_cyc.size() - wc0, 32'd4);
    if (wr_cyc.size() - wc0 == 4) begin
      for (int i = 0; i < 3; i++) check("echo_spacing", wr_cyc[wc0+i+1] - wr_cyc[wc0+i], 32'd2);
    end

    pl = '{8'h10, 8'h20, 8'h30, 8'h40};
    exp_q = '{8'h04, 8'h40, 8'h30, 8'h20, 8'h10};
    send_pkt(4, 2'b01, 1'b0, 1'b0);

    // Pin the model against a hand-computed checksum reply, then send it.
    pl = '{8'hF0, 8'h0F};
    model(2, 2'b10);
    check("model_size", exp_q.size(), 32'd4);
    if (exp_q.size() == 4) begin
      check("model_hdr", {24'd0, exp_q[0]}, 32'h03);
      check("model_p0", {24'd0, exp_q[1]}, 32'hF0);
      check("model_p1", {24'd0, exp_q[2]}, 32'h0F);
      check("model_csum", {24'd0, exp_q[3]}, 32'hFF);
    end
    send_pkt(2, 2'b10, 1'b0, 1'b0);

    pl.delete();
    for (int i = 0; i < 65; i++) pl.push_back(8'($urandom));
    exp_q = '{8'hFF};
    pkt_err_exp++;
    send_pkt(65, 2'b00, 1'b0, 1'b0);

    wc0 = wr_cyc.size();
    pl.delete();
    send_pkt(0, 2'b00, 1'b0, 1'b0);
    check("zero_len_no_write", wr_cyc.size() - wc0, 32'd0);

    busy = 1'b1;
    exp_q = '{8'h01, 8'h5A};
    wc0 = wr_cyc.size();
    mode = 2'b00;
    send_word(8'h01, 0);
    send_word(8'h5A, 0);
    repeat (10) tick();
    check("no_write_while_busy", wr_cyc.size() - wc0, 32'd0);
    busy = 1'b0;
    wait_idle("bp");
    check("bp_write_count", wr_cyc.size() - wc0, 32'd2);
    check("bp_drained", exp_q.size(), 32'd0);

    mode = 2'b00;
    send_word(8'h05, 0);
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    rst_L = 1'b0;
    tick();
    rst_L = 1'b1;
    @(negedge clk);
    check("midrst_write", {31'd0, write}, 32'd0);
    check("midrst_byte_send", {24'd0, byte_send}, 32'd0);
    check("midrst_idle", {31'd0, idle}, 32'd1);
    tick();
    pl = '{8'h77};
    exp_q = '{8'h01, 8'h77};
    send_pkt(1, 2'b00, 1'b0, 1'b0);

    busy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) n = 0;
      else if (r == 1) n = MAX_LEN;
      else if (r == 2) n = int'($urandom_range(MAX_LEN + 1, 255));
      else n = int'($urandom_range(1, MAX_LEN));
      m = 2'($urandom);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      send_pkt(n, m, 1'b1, 1'b1);
    end
    busy_rand = 1'b0;
    busy      = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_packet_processor.md
Name: spi_packet_processor

Overview:
Parametrised successor to the single-mode SPI echo processor. Sits between the SPI slave byte interface (byte_recv/valid in, byte_send/write/busy out) and receives length-prefixed packets into an internal buffer. It then returns them in one of several modes: echo, reversed, or echo plus XOR checksum. Oversized packets are detected, discarded and answered with an error reply.

Parameters:
DATA_W, 8, width of one SPI word; the length header uses the same width.
MAX_LEN, 64, maximum payload words buffered; must satisfy 1 <= MAX_LEN <= 2^DATA_W - 2.
ERR_CODE, all-ones (DATA_W bits), word sent as the error reply.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_L  in  1  reset; synchronous, active-low.
byte_recv  in  DATA_W  received SPI word; qualified by valid.
valid  in  1  one-cycle strobe: byte_recv holds a new word.
busy  in  1  SPI transmitter is occupied; no write may be issued.
mode  in  2  reply mode, sampled only when a header is accepted: 00 echo, 01 reverse, 10 echo+checksum, 11 treated as 00.
write  out  1  one-cycle strobe: byte_send is to be transmitted.
byte_send  out  DATA_W  word to transmit; held stable between write pulses.
pkt_err  out  1  one-cycle pulse when an oversized header is accepted.
idle  out  1  high only in IDLE state.

Behaviour:
- Reset (rst_L low at a rising edge):
  - write=0, byte_send=0, pkt_err=0, idle=1, state=IDLE.
  - Counters and checksum are cleared; buffer contents are not cleared.
  - Reset mid-packet abandons the packet. No further write pulses occur.
- States: IDLE, RECV, DROP, HDR, SEND, CSUM, ERR.
- IDLE: on valid, latch N=byte_recv and latch mode.
  - N=0: stay in IDLE, no reply.
  - 1<=N<=MAX_LEN: go to RECV, with index=0 and chk=0.
  - N>MAX_LEN: pulse pkt_err next cycle, index=0, go to DROP.
- RECV: each valid writes buffer[index]=byte_recv, sets chk^=byte_recv and index+1. The word at index==N-1 is the last; it moves the block to HDR. Exactly N payload words are stored.
- DROP: counts N valid words without storing them, then goes to ERR.
- Write handshake, applies to all send states: write may pulse only if busy==0 and write==0 in the current cycle. Consecutive writes are therefore at least 2 cycles apart. byte_send updates on the same edge that raises write.
- HDR: send N, or N+1 in checksum mode. Then go to SEND with index=0 (echo) or index=N-1 (reverse).
- SEND: send buffer[index], then index+1 (echo) or index-1 (reverse).
  - After the Nth word, go to CSUM in checksum mode, else to IDLE.
- CSUM: send chk, then go to IDLE.
- ERR: send ERR_CODE once, then go to IDLE.
- Latency:
  - The last payload valid at edge k puts the block in HDR. The header write pulse is registered at edge k+1 at the earliest, if busy is low.
  - A header accepted at edge k returns to IDLE after the final reply write.
- valid is ignored in HDR, SEND, CSUM and ERR; those words are lost.
- mode changes outside IDLE header acceptance are ignored.
- busy rising in the same cycle write is high has no effect on that write; it only blocks the next one.
- Index arithmetic: index is ceil(log2(MAX_LEN+1)) bits wide and never wraps within a legal packet. The length comparison is unsigned, DATA_W bits.
- Checksum: bitwise XOR of the N payload words, DATA_W bits.

Test Plan:
- Echo, DATA_W=8, MAX_LEN=64, mode=00: send 03,A1,B2,C3 with busy=0.
  - Required: writes 03,A1,B2,C3, each 2 cycles apart; then idle=1.
- Reverse, mode=01: send 04,10,20,30,40.
  - Required: writes 04,40,30,20,10.
- Checksum, mode=10: send 02,F0,0F.
  - Required: writes 03,F0,0F,FF.
- Oversize: header 41 (65 > MAX_LEN), then 65 valid words.
  - Required: pkt_err pulses once; no buffer writes; single write FF; then idle.
- Zero length and backpressure: send 00.
  - Required: no write, idle stays 1.
  - Then send 01,5A with busy held high 10 cycles.
  - Required: no write while busy; writes 01,5A after busy falls; byte_send stable throughout.
- Reset mid-operation: rst_L low for 1 edge after the 2nd payload word of 05,....
  - Required: write=0, byte_send=0, idle=1 next cycle.
  - Then a fresh 01,77 packet echoes as 01,77.
